// File: rtl/amba3_apb_slave_mem.sv
// APB3 completer with word-addressed register memory; each transfer takes WAIT_CYCLES+2 cycles and pready/prdata/pslverr are registered.
// The requester is held off by pready=0 while the wait counter runs; illegal addresses complete with pslverr and leave memory untouched.
module amba3_apb_slave_mem #(
    parameter int ADDR_SIZE   = 32,
    parameter int DATA_SIZE   = 32,
    parameter int MEM_DEPTH   = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                 pclk,
    input  logic                 preset_n,
    input  logic [ADDR_SIZE-1:0] paddr,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [DATA_SIZE-1:0] pwdata,
    output logic                 pready,
    output logic [DATA_SIZE-1:0] prdata,
    output logic                 pslverr,
    output logic                 proto_err
);
    localparam int OFS = $clog2(DATA_SIZE / 8);
    localparam int IW  = $clog2(MEM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] ALIGN_MASK = ADDR_SIZE'((64'd1 << OFS) - 64'd1);
    localparam logic [7:0] WAIT_LD = 8'(WAIT_CYCLES);

    typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

    state_t                 r_state;
    logic [ADDR_SIZE-1:0]   r_addr;
    logic                   r_write;
    logic [DATA_SIZE-1:0]   r_wdata;
    logic [7:0]             r_cnt;
    logic                   r_pready;
    logic [DATA_SIZE-1:0]   r_prdata;
    logic                   r_pslverr;
    logic                   r_proto_err;
    logic [DATA_SIZE-1:0]   r_mem [MEM_DEPTH];

    state_t                 w_state_nxt;
    logic [7:0]             w_cnt_nxt;
    logic                   w_pready_nxt;
    logic [DATA_SIZE-1:0]   w_prdata_nxt;
    logic                   w_pslverr_nxt;
    logic                   w_proto_nxt;
    logic                   w_capture;
    logic                   w_we;
    logic [IW-1:0]          w_in_idx;
    logic [IW-1:0]          w_cap_idx;
    logic                   w_in_ill;
    logic                   w_cap_ill;
    logic [DATA_SIZE-1:0]   w_in_word;
    logic [DATA_SIZE-1:0]   w_cap_word;
    logic                   w_changed;

    function automatic logic f_illegal(input logic [ADDR_SIZE-1:0] a);
        f_illegal = ((a & ALIGN_MASK) != '0) || ((a >> (OFS + IW)) != '0);
    endfunction

    assign w_in_idx   = paddr[OFS+IW-1:OFS];
    assign w_cap_idx  = r_addr[OFS+IW-1:OFS];
    assign w_in_ill   = f_illegal(paddr);
    assign w_cap_ill  = f_illegal(r_addr);
    assign w_in_word  = r_mem[w_in_idx];
    assign w_cap_word = r_mem[w_cap_idx];
    assign w_changed  = (paddr != r_addr) || (pwrite != r_write) || (pwdata != r_wdata);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pready_nxt  = 1'b0;
        w_prdata_nxt  = '0;
        w_pslverr_nxt = 1'b0;
        w_proto_nxt   = r_proto_err;
        w_capture     = 1'b0;
        w_we          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (psel && !penable) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_ACCESS;
                    w_cnt_nxt   = WAIT_LD;
                    // With no wait states the response must be ready in the first access cycle.
                    if (WAIT_CYCLES == 0) begin
                        w_pready_nxt  = 1'b1;
                        w_pslverr_nxt = w_in_ill;
                        w_prdata_nxt  = (!pwrite && !w_in_ill) ? w_in_word : '0;
                    end
                end else if (psel && penable) begin
                    w_proto_nxt = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (!psel) begin
                    w_proto_nxt = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    if (w_changed) begin
                        w_proto_nxt = 1'b1;
                    end
                    if (penable && r_pready) begin
                        w_we        = r_write && !w_cap_ill;
                        w_state_nxt = ST_IDLE;
                    end else if (penable && (r_cnt != 8'd0)) begin
                        w_cnt_nxt = r_cnt - 8'd1;
                        if (r_cnt == 8'd1) begin
                            w_pready_nxt  = 1'b1;
                            w_pslverr_nxt = w_cap_ill;
                            w_prdata_nxt  = (!r_write && !w_cap_ill) ? w_cap_word : '0;
                        end
                    end else if (!penable) begin
                        w_pready_nxt  = r_pready;
                        w_pslverr_nxt = r_pslverr;
                        w_prdata_nxt  = r_prdata;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_pready    <= 1'b0;
            r_prdata    <= '0;
            r_pslverr   <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pready    <= w_pready_nxt;
            r_prdata    <= w_prdata_nxt;
            r_pslverr   <= w_pslverr_nxt;
            r_proto_err <= w_proto_nxt;
            if (w_capture) begin
                r_addr  <= paddr;
                r_write <= pwrite;
                r_wdata <= pwdata;
            end
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_we) begin
            r_mem[w_cap_idx] <= r_wdata;
        end
    end

    assign pready    = r_pready;
    assign prdata    = r_prdata;
    assign pslverr   = r_pslverr;
    assign proto_err = r_proto_err;
endmodule

// File: tb/tb_amba3_apb_slave_mem.sv
// Bench for amba3_apb_slave_mem: two instances (0 and 3 wait states) share the bus, each with its own psel.
// Randomized and directed APB traffic is compared against a word-array reference model.
module tb_amba3_apb_slave_mem;
    logic        pclk = 1'b0;
    logic        preset_n = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic        pwrite = 1'b0;
    logic        penable = 1'b0;
    logic        psel0 = 1'b0;
    logic        psel3 = 1'b0;
    logic        pready0, pslverr0, proto0;
    logic        pready3, pslverr3, proto3;
    logic [31:0] prdata0, prdata3;

    int checks = 0;
    int errors = 0;
    int cur = 0;
    logic [31:0] mem_m [2][16];
    logic        proto_m [2];

    logic        pready_s, pslverr_s, proto_s;
    logic [31:0] prdata_s;

    always #5 pclk = ~pclk;

    amba3_apb_slave_mem #(.WAIT_CYCLES(0)) u_dut0 (
        .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .psel(psel0), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pready(pready0), .prdata(prdata0),
        .pslverr(pslverr0), .proto_err(proto0)
    );

    amba3_apb_slave_mem #(.WAIT_CYCLES(3)) u_dut3 (
        .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .psel(psel3), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pready(pready3), .prdata(prdata3),
        .pslverr(pslverr3), .proto_err(proto3)
    );

    always_comb begin
        pready_s  = (cur == 0) ? pready0  : pready3;
        prdata_s  = (cur == 0) ? prdata0  : prdata3;
        pslverr_s = (cur == 0) ? pslverr0 : pslverr3;
        proto_s   = (cur == 0) ? proto0   : proto3;
    end

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic illegal_m(input logic [31:0] a);
        return ((a % 4) != 0) || (a >= 32'd64);
    endfunction

    function automatic logic [31:0] exp_rd(input int d, input logic [31:0] a);
        if (illegal_m(a)) return 32'h0;
        return mem_m[d][a / 4];
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            proto_m[d] = 1'b0;
            for (int i = 0; i < 16; i++) mem_m[d][i] = 32'h0;
        end
    endtask

    task automatic apb_xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic err, output int cyc, output logic rdy_after);
        int budget;
        cur = d;
        @(posedge pclk); #1;
        if (d == 0) psel0 = 1'b1; else psel3 = 1'b1;
        penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        cyc = 1;
        @(posedge pclk); #1;
        penable = 1'b1;
        cyc = 2;
        budget = 0;
        while (pready_s !== 1'b1 && budget < 300) begin
            @(posedge pclk); #1;
            cyc++;
            budget++;
        end
        if (pready_s !== 1'b1) begin
            checks++; errors++;
            $display("FAIL xfer_timeout dut=%0d addr=%h pready=%b required=1", d, a, pready_s);
        end
        rd  = prdata_s;
        err = pslverr_s;
        @(posedge pclk); #1;
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
        rdy_after = pready_s;
        if (wr && !illegal_m(a)) mem_m[d][a / 4] = wd;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        got = {pready0, pslverr0, proto0, |prdata0, pready3, pslverr3, proto3, |prdata3};
        checks++;
        if (got !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got=%b required=00000000", got);
        end
    endtask

    task automatic test_read_zero_wait();
        logic [31:0] rd; logic err, ra; int cyc;
        apb_xfer(0, 1'b0, 32'h0C, 32'h0, rd, err, cyc, ra);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rd0_data got=%h required=0", rd); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rd0_err got=%b required=0", err); end
        checks++; if (cyc !== 2) begin errors++; $display("FAIL rd0_cycles got=%0d required=2", cyc); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL rd0_ready_after got=%b required=0", ra); end
    endtask

    task automatic test_write_read_wait3();
        logic [31:0] rd; logic err, ra; int cyc;
        apb_xfer(1, 1'b1, 32'h08, 32'hDEADBEEF, rd, err, cyc, ra);
        checks++; if (cyc !== 5) begin errors++; $display("FAIL wr3_cycles got=%0d required=5", cyc); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr3_err got=%b required=0", err); end
        apb_xfer(1, 1'b0, 32'h08, 32'h0, rd, err, cyc, ra);
        checks++; if (cyc !== 5) begin errors++; $display("FAIL rd3_cycles got=%0d required=5", cyc); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd3_data got=%h required=deadbeef", rd); end
        for (int i = 0; i < 16; i++) begin
            apb_xfer(1, 1'b0, 32'(i * 4), 32'h0, rd, err, cyc, ra);
            checks++;
            if (rd !== exp_rd(1, 32'(i * 4))) begin
                errors++; $display("FAIL rd3_word%0d got=%h required=%h", i, rd, exp_rd(1, 32'(i * 4)));
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] rd; logic err, ra; int cyc;
        logic [31:0] bad [2];
        bad[0] = 32'h40; bad[1] = 32'h06;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 2; k++) begin
                apb_xfer(d, 1'b1, bad[k], 32'hFFFF_FFFF, rd, err, cyc, ra);
                checks++;
                if (err !== 1'b1) begin errors++; $display("FAIL illegal_err dut=%0d addr=%h got=%b required=1", d, bad[k], err); end
                checks++;
                if (cyc !== wait_of(d) + 2) begin errors++; $display("FAIL illegal_cycles dut=%0d got=%0d required=%0d", d, cyc, wait_of(d) + 2); end
            end
        end
        for (int i = 0; i < 16; i++) begin
            apb_xfer(0, 1'b0, 32'(i * 4), 32'h0, rd, err, cyc, ra);
            checks++;
            if (rd !== 32'h0) begin errors++; $display("FAIL illegal_mem word%0d got=%h required=0", i, rd); end
        end
        apb_xfer(1, 1'b0, 32'h40, 32'h0, rd, err, cyc, ra);
        checks++; if (rd !== 32'h0 || err !== 1'b1) begin errors++; $display("FAIL illegal_read got=%h/%b required=0/1", rd, err); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic err, ra; int cyc;
        for (int d = 0; d < 2; d++) begin
            apb_xfer(d, 1'b1, 32'h00, 32'h1, rd, err, cyc, ra);
            apb_xfer(d, 1'b1, 32'h3C, 32'h2, rd, err, cyc, ra);
            apb_xfer(d, 1'b0, 32'h00, 32'h0, rd, err, cyc, ra);
            checks++; if (rd !== 32'h1) begin errors++; $display("FAIL b2b_rd0 dut=%0d got=%h required=1", d, rd); end
            apb_xfer(d, 1'b0, 32'h3C, 32'h0, rd, err, cyc, ra);
            checks++; if (rd !== 32'h2) begin errors++; $display("FAIL b2b_rd3c dut=%0d got=%h required=2", d, rd); end
            checks++; if (proto_s !== 1'b0) begin errors++; $display("FAIL b2b_proto dut=%0d got=%b required=0", d, proto_s); end
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic err, ra; int cyc;
        logic seen;
        cur = 1;
        @(posedge pclk); #1;
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h55;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel3 = 1'b0; penable = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge pclk); #1;
            if (pready3 === 1'b1) seen = 1'b1;
        end
        proto_m[1] = 1'b1;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_pready got=1 required=0"); end
        checks++; if (proto3 !== 1'b1) begin errors++; $display("FAIL abort_proto got=%b required=1", proto3); end
        checks++; if (proto0 !== 1'b0) begin errors++; $display("FAIL abort_proto_other got=%b required=0", proto0); end
        apb_xfer(1, 1'b0, 32'h04, 32'h0, rd, err, cyc, ra);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL abort_rd got=%h required=0", rd); end
        // penable without a setup phase must be ignored and flagged
        cur = 0;
        @(posedge pclk); #1;
        psel0 = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h77;
        @(posedge pclk); #1;
        psel0 = 1'b0; penable = 1'b0;
        proto_m[0] = 1'b1;
        checks++; if (pready0 !== 1'b0) begin errors++; $display("FAIL idle_enable_pready got=%b required=0", pready0); end
        checks++; if (proto0 !== 1'b1) begin errors++; $display("FAIL idle_enable_proto got=%b required=1", proto0); end
        apb_xfer(0, 1'b0, 32'h20, 32'h0, rd, err, cyc, ra);
        checks++; if (rd !== exp_rd(0, 32'h20)) begin errors++; $display("FAIL idle_enable_rd got=%h required=%h", rd, exp_rd(0, 32'h20)); end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, wd, exp; logic err, ra, wr; int cyc, d;
        for (int n = 0; n < 60; n++) begin
            d  = $urandom_range(0, 1);
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(0, 127));
            else a = 32'($urandom_range(0, 15) * 4);
            exp = wr ? 32'h0 : exp_rd(d, a);
            apb_xfer(d, wr, a, wd, rd, err, cyc, ra);
            checks++;
            if (rd !== exp || err !== illegal_m(a) || cyc !== wait_of(d) + 2 || ra !== 1'b0 || proto_s !== proto_m[d]) begin
                errors++;
                $display("FAIL rand%0d dut=%0d wr=%b addr=%h got rd=%h err=%b cyc=%0d ra=%b proto=%b required rd=%h err=%b cyc=%0d ra=0 proto=%b",
                         n, d, wr, a, rd, err, cyc, ra, proto_s, exp, illegal_m(a), wait_of(d) + 2, proto_m[d]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err, ra; int cyc;
        apb_xfer(0, 1'b1, 32'h10, 32'hA5, rd, err, cyc, ra);
        cur = 0;
        @(posedge pclk); #1;
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10;
        @(posedge pclk); #1;
        penable = 1'b1;
        checks++; if (pready0 !== 1'b1 || prdata0 !== 32'hA5) begin errors++; $display("FAIL mid_pre got=%b/%h required=1/000000a5", pready0, prdata0); end
        preset_n = 1'b0;
        #1;
        checks++;
        if (pready0 !== 1'b0 || prdata0 !== 32'h0 || pslverr0 !== 1'b0 || proto0 !== 1'b0 || proto3 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got rdy=%b rd=%h err=%b p0=%b p3=%b required all 0", pready0, prdata0, pslverr0, proto0, proto3);
        end
        psel0 = 1'b0; penable = 1'b0;
        model_clear();
        @(posedge pclk); #1;
        preset_n = 1'b1;
        apb_xfer(0, 1'b0, 32'h10, 32'h0, rd, err, cyc, ra);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_rd got=%h required=0", rd); end
        checks++; if (proto0 !== 1'b0) begin errors++; $display("FAIL mid_proto got=%b required=0", proto0); end
    endtask

    initial begin
        model_clear();
        #23;
        test_reset();
        @(posedge pclk); #1;
        preset_n = 1'b1;
        test_read_zero_wait();
        test_write_read_wait3();
        test_illegal();
        test_back_to_back();
        test_abort();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout time=%0t limit=2000000", $time);
        $fatal(1, "bench timeout");
    end
endmodule
